vid_frame_source: RTL and testbench
===================================

Name: vid_frame_source

Overview:
- Stream transmitter for the vision pipeline. Reads a stored frame of packed {dx, dy, grad} words from a synchronous-read frame buffer and emits them as a raster video stream using hvalid/vvalid framing with horizontal and vertical blanking.
- Drives processing blocks and sink-side capture from a known frame.
- Read side of the capture path: write a frame at address 0..H_ACT*V_ACT-1, replay it with identical raster ordering.

Parameters:
- IW0, 8, grad field width.
- IW1, 8, dx and dy field width.
- AW, 21, frame-buffer address width.
- H_ACT, 1920, active pixels per line.
- V_ACT, 1080, active lines per frame.
- H_BLANK, 280, blanking cycles per line (hvalid low).
- V_BLANK, 45, blanking lines per frame (vvalid low).
- RD_LAT, 2, frame-buffer read latency in cycles, rd_en to rd_data; legal 1..4.

Ports:
- clk  in  1  clock.
- rst_b  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a frame.
- cont  in  1  continuous mode; sampled at the last cycle of each frame.
- busy  out  1  high from frame start through the end of vertical blanking.
- frame_done  out  1  one-cycle pulse on the final cycle of vertical blanking.
- rd_en  out  1  frame-buffer read enable.
- rd_addr  out  AW  frame-buffer read address.
- rd_data  in  IW1+IW1+IW0  read data, packed {dx, dy, grad}, valid RD_LAT cycles after rd_en.
- hvalid  out  1  active pixel on this line.
- vvalid  out  1  active-line region of the frame.
- dx_out  out  IW1  pixel dx.
- dy_out  out  IW1  pixel dy.
- grad_out  out  IW0  pixel grad.

Behaviour:
- Reset: asynchronous assertion of rst_b clears every register.
  - state = IDLE.
  - All outputs read 0: busy, frame_done, rd_en, rd_addr, hvalid, vvalid, and all data outputs.
  - Reset mid-frame abandons the frame immediately. No partial completion, no frame_done.
- State machine: IDLE, ACTIVE, VBLANK.
  - IDLE -> ACTIVE when start=1. The next cycle begins line 0, pixel 0, with rd_addr=0.
  - ACTIVE runs V_ACT lines of H_ACT+H_BLANK cycles each. The first H_ACT cycles of each line are active pixels. After the last cycle of line V_ACT-1, go to VBLANK.
  - VBLANK runs V_BLANK*(H_ACT+H_BLANK) cycles. On its last cycle, pulse frame_done. Then go to ACTIVE if cont=1 (no idle gap, rd_addr=0), otherwise go to IDLE.
  - start is ignored outside IDLE.
- Counters:
  - h_cnt counts 0..H_ACT+H_BLANK-1 and wraps.
  - v_cnt counts 0..V_ACT+V_BLANK-1.
  - rd_addr increments once per active pixel and reaches H_ACT*V_ACT-1 on the last pixel. Width AW, no wrap within a frame.
- Pre-stage timing, combinational from the counters:
  - hv_pre = ACTIVE && h_cnt<H_ACT.
  - vv_pre = ACTIVE.
  - rd_en = hv_pre, registered together with rd_addr.
- Alignment:
  - hvalid, vvalid, and busy-derived framing are delayed by RD_LAT cycles through a shift pipeline, so hvalid coincides exactly with the corresponding rd_data.
  - Data outputs register rd_data split as {dx, dy, grad}. They are forced to 0 whenever the aligned hvalid is 0.
  - Latency: start sampled at edge k -> rd_en high after edge k+1 -> hvalid and first pixel high after edge k+1+RD_LAT.
- vvalid:
  - Stays high across H_BLANK gaps within the active region.
  - Drops after the final H_BLANK of line V_ACT-1, delayed by RD_LAT.
  - In continuous mode, consecutive frames are separated by exactly V_BLANK lines of vvalid=0.
- Frame length: exactly (H_ACT+H_BLANK)*(V_ACT+V_BLANK) cycles, start to frame_done inclusive of blanking.
- busy is high from the cycle after start is accepted until the cycle after frame_done.

Optional Feature:
- Macro VID_SRC_PATTERN_EN.
- When defined, the frame buffer is bypassed:
  - rd_en is held at 0.
  - Data outputs carry a generated pattern aligned to hvalid: dx_out = h_cnt[IW1-1:0], dy_out = v_cnt[IW1-1:0], grad_out = (h_cnt^v_cnt)[IW0-1:0].
  - Timing is identical to normal mode, including RD_LAT alignment.
- When not defined, data comes from rd_data only and no pattern logic is present.

Decomposition:
- Package vid_pkg holds:
  - the state enum (IDLE, ACTIVE, VBLANK);
  - the localparam for packed pixel width (IW1+IW1+IW0);
  - a function returning line length H_ACT+H_BLANK.
- One sub-module, vid_timing_gen, contains the h/v counters and the pre-stage hv_pre/vv_pre/frame-end flags.
- The top contains the state machine, address counter, RD_LAT alignment pipeline, and output registers.

Test Plan:
- Small frame, single-shot: H_ACT=4, V_ACT=3, H_BLANK=2, V_BLANK=1, RD_LAT=2. The memory model returns data = address.
  - start pulse -> hvalid high 3 cycles after the start edge.
  - 12 pixels out with {dx,dy,grad} = 0..11 in order.
  - frame_done exactly 24 cycles after the start edge; busy then falls and outputs idle at 0.
- Continuous mode: same parameters, cont=1 -> three frames back to back, each separated by exactly 6 cycles of vvalid=0, with rd_addr restarting at 0 each frame.
- start while busy: pulse start mid-frame -> no effect on counters; a single frame_done.
- Async reset mid-line: deassert rst_b during pixel 5 -> all outputs 0 immediately, no frame_done. The next start produces a clean frame from address 0.
- RD_LAT sweep over 1 and 4 -> hvalid/data alignment holds and first-pixel latency equals 1+RD_LAT.
- VID_SRC_PATTERN_EN defined -> rd_en never asserts; pixel (h=2, v=1) outputs dx=2, dy=1, grad=3.

Source files
------------

// File: rtl/vid_pkg.sv
// Shared state encoding, default widths and raster helpers for the frame source.
// Optional build: VID_SRC_PATTERN_EN replaces frame-buffer data with a counter pattern.
package vid_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    VBLANK = 2'd2
  } vid_state_e;

  localparam int VID_IW0   = 8;
  localparam int VID_IW1   = 8;
  localparam int VID_PIX_W = VID_IW1 + VID_IW1 + VID_IW0;

  function automatic int line_len(input int h_act, input int h_blank);
    return h_act + h_blank;
  endfunction

endpackage

// File: rtl/vid_timing_gen.sv
// Raster h/v counters plus the pre-stage framing and end-of-region flags.
// With VID_SRC_PATTERN_EN defined it also forms the counter-derived test pixel.
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int IW0     = VID_IW0,
  parameter int IW1     = VID_IW1,
  parameter int H_ACT   = 1920,
  parameter int V_ACT   = 1080,
  parameter int H_BLANK = 280,
  parameter int V_BLANK = 45
) (
  input  logic clk,
  input  logic rst_b,
  input  logic run,
  input  logic active,
  output logic hv_pre,
  output logic vv_pre,
  output logic act_end,
  output logic frame_end
`ifdef VID_SRC_PATTERN_EN
  ,
  output logic [IW1+IW1+IW0-1:0] pat_pix
`endif
);

  localparam int LL = line_len(H_ACT, H_BLANK);
  localparam int VT = V_ACT + V_BLANK;
  localparam int HW = (LL > 1) ? $clog2(LL) : 1;
  localparam int VW = (VT > 1) ? $clog2(VT) : 1;

  localparam logic [HW-1:0] H_LAST     = HW'(LL - 1);
  localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACT);
  localparam logic [VW-1:0] V_LAST     = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACT - 1);

  logic [HW-1:0] h_cnt_d, h_cnt_q;
  logic [VW-1:0] v_cnt_d, v_cnt_q;

  // Counters idle at zero and wrap to zero after the last blanking line.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run) begin
      h_cnt_d = {HW{1'b0}};
      v_cnt_d = {VW{1'b0}};
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = {HW{1'b0}};
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = {VW{1'b0}};
      end else begin
        v_cnt_d = v_cnt_q + VW'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      h_cnt_q <= {HW{1'b0}};
      v_cnt_q <= {VW{1'b0}};
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    hv_pre    = active && (h_cnt_q < H_ACT_C);
    vv_pre    = active;
    act_end   = active && (h_cnt_q == H_LAST) && (v_cnt_q == V_ACT_LAST);
    frame_end = run && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  end

`ifdef VID_SRC_PATTERN_EN
  logic [31:0] h_ext, v_ext, hv_xor;

  always_comb begin
    h_ext   = 32'(h_cnt_q);
    v_ext   = 32'(v_cnt_q);
    hv_xor  = h_ext ^ v_ext;
    pat_pix = {h_ext[IW1-1:0], v_ext[IW1-1:0], hv_xor[IW0-1:0]};
  end
`endif

endmodule

// File: rtl/vid_frame_source.sv
// Raster frame source: replays a stored {dx, dy, grad} frame as hvalid/vvalid video.
// Define VID_SRC_PATTERN_EN to bypass the frame buffer with a counter-derived pattern.
module vid_frame_source
  import vid_pkg::*;
#(
  parameter int IW0     = VID_IW0,
  parameter int IW1     = VID_IW1,
  parameter int AW      = 21,
  parameter int H_ACT   = 1920,
  parameter int V_ACT   = 1080,
  parameter int H_BLANK = 280,
  parameter int V_BLANK = 45,
  parameter int RD_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   start,
  input  logic                   cont,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   rd_en,
  output logic [AW-1:0]          rd_addr,
  input  logic [IW1+IW1+IW0-1:0] rd_data,
  output logic                   hvalid,
  output logic                   vvalid,
  output logic [IW1-1:0]         dx_out,
  output logic [IW1-1:0]         dy_out,
  output logic [IW0-1:0]         grad_out
);

  localparam int PW = IW1 + IW1 + IW0;

  vid_state_e state_d, state_q;

  logic run, in_active;
  logic hv_pre, vv_pre, act_end, frame_end;

  logic busy_d, busy_q;
  logic fd_d, fd_q;
  logic rd_en_d, rd_en_q;
  logic [AW-1:0] addr_d, addr_q;
  logic [AW-1:0] rd_addr_d, rd_addr_q;

  logic [RD_LAT-1:0] hv_pipe_d, hv_pipe_q;
  logic [RD_LAT-1:0] vv_pipe_d, vv_pipe_q;
  logic hvalid_d, hvalid_q;
  logic vvalid_d, vvalid_q;
  logic [PW-1:0] src_pix;
  logic [PW-1:0] pix_d, pix_q;

`ifdef VID_SRC_PATTERN_EN
  logic [PW-1:0] pat_pre;
  logic [PW-1:0] pat_pipe_d [RD_LAT];
  logic [PW-1:0] pat_pipe_q [RD_LAT];
`endif

  assign run       = (state_q != IDLE);
  assign in_active = (state_q == ACTIVE);

  vid_timing_gen #(
    .IW0     (IW0),
    .IW1     (IW1),
    .H_ACT   (H_ACT),
    .V_ACT   (V_ACT),
    .H_BLANK (H_BLANK),
    .V_BLANK (V_BLANK)
  ) u_timing (
    .clk       (clk),
    .rst_b     (rst_b),
    .run       (run),
    .active    (in_active),
    .hv_pre    (hv_pre),
    .vv_pre    (vv_pre),
    .act_end   (act_end),
    .frame_end (frame_end)
`ifdef VID_SRC_PATTERN_EN
    ,
    .pat_pix   (pat_pre)
`endif
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start only matters in IDLE; cont is looked at on the last blanking cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (act_end) begin
          state_d = VBLANK;
        end else begin
          state_d = ACTIVE;
        end
      end
      VBLANK: begin
        if (frame_end) begin
          state_d = cont ? ACTIVE : IDLE;
        end else begin
          state_d = VBLANK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_q != IDLE);
    fd_d   = (state_q == VBLANK) && frame_end;
`ifdef VID_SRC_PATTERN_EN
    rd_en_d   = 1'b0;
    addr_d    = {AW{1'b0}};
    rd_addr_d = {AW{1'b0}};
`else
    rd_en_d = hv_pre;
    // addr_q is the next address to issue; it restarts at every frame boundary.
    if ((state_q == IDLE) || frame_end) begin
      addr_d = {AW{1'b0}};
    end else if (hv_pre) begin
      addr_d = addr_q + AW'(1);
    end else begin
      addr_d = addr_q;
    end
    if (hv_pre) begin
      rd_addr_d = addr_q;
    end else if (state_q == IDLE) begin
      rd_addr_d = {AW{1'b0}};
    end else begin
      rd_addr_d = rd_addr_q;
    end
`endif
  end

  // Framing is delayed so hvalid lands on the same edge as the captured read data.
  always_comb begin
    hv_pipe_d    = hv_pipe_q;
    vv_pipe_d    = vv_pipe_q;
    hv_pipe_d[0] = hv_pre;
    vv_pipe_d[0] = vv_pre;
    for (int i = 1; i < RD_LAT; i++) begin
      hv_pipe_d[i] = hv_pipe_q[i-1];
      vv_pipe_d[i] = vv_pipe_q[i-1];
    end
    hvalid_d = hv_pipe_q[RD_LAT-1];
    vvalid_d = vv_pipe_q[RD_LAT-1];
`ifdef VID_SRC_PATTERN_EN
    src_pix = pat_pipe_q[RD_LAT-1];
`else
    src_pix = rd_data;
`endif
    if (hvalid_d) begin
      pix_d = src_pix;
    end else begin
      pix_d = {PW{1'b0}};
    end
  end

`ifdef VID_SRC_PATTERN_EN
  always_comb begin
    pat_pipe_d[0] = pat_pre;
    for (int i = 1; i < RD_LAT; i++) begin
      pat_pipe_d[i] = pat_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pat_pipe_q[i] <= {PW{1'b0}};
      end
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        pat_pipe_q[i] <= pat_pipe_d[i];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= {AW{1'b0}};
      rd_addr_q <= {AW{1'b0}};
      hv_pipe_q <= {RD_LAT{1'b0}};
      vv_pipe_q <= {RD_LAT{1'b0}};
      hvalid_q  <= 1'b0;
      vvalid_q  <= 1'b0;
      pix_q     <= {PW{1'b0}};
    end else begin
      busy_q    <= busy_d;
      fd_q      <= fd_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      hv_pipe_q <= hv_pipe_d;
      vv_pipe_q <= vv_pipe_d;
      hvalid_q  <= hvalid_d;
      vvalid_q  <= vvalid_d;
      pix_q     <= pix_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign hvalid     = hvalid_q;
  assign vvalid     = vvalid_q;
  assign dx_out     = pix_q[PW-1 -: IW1];
  assign dy_out     = pix_q[IW0 +: IW1];
  assign grad_out   = pix_q[IW0-1:0];

endmodule

// File: tb/tb_vid_frame_source.sv
// Bench for vid_frame_source on a 4x3 frame (2 h-blank, 1 v-blank line) at RD_LAT 2, 1 and 4.
// The memory model's address register is the DUT's rd_addr flop, so data arrives RD_LAT-1 cycles later.
module tb_vid_frame_source;

  localparam int H_ACT   = 4;
  localparam int V_ACT   = 3;
  localparam int H_BLANK = 2;
  localparam int V_BLANK = 1;
  localparam int AW      = 21;
  localparam int IW0     = 8;
  localparam int IW1     = 8;
  localparam int PW      = IW1 + IW1 + IW0;
  localparam int LL      = H_ACT + H_BLANK;
  localparam int ACT_CYC = LL * V_ACT;
  localparam int FRAME   = LL * (V_ACT + V_BLANK);
  localparam int NI      = 3;
  localparam int NV      = 30;

`ifdef VID_SRC_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  typedef struct {
    bit                     start;
    bit                     busy;
    bit                     fd;
    bit                     rde;
    bit                     chk_addr;
    logic [AW-1:0]          addr;
    logic [NI-1:0]          hv;
    logic [NI-1:0]          vv;
    logic [NI-1:0][PW-1:0]  pix;
  } vec_t;

  vec_t vecs [NV];

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;

  logic          busy_w  [NI];
  logic          fd_w    [NI];
  logic          rde_w   [NI];
  logic          hv_w    [NI];
  logic          vv_w    [NI];
  logic [AW-1:0] addr_w  [NI];
  logic [PW-1:0] rdata_w [NI];
  logic [IW1-1:0] dx_w   [NI];
  logic [IW1-1:0] dy_w   [NI];
  logic [IW0-1:0] gr_w   [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  function automatic logic [PW-1:0] mem_word(input logic [AW-1:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b ^ 8'hA0, b ^ 8'h50, b};
  endfunction

  function automatic bit act_f(input int f);
    return (f >= 0) && (f < ACT_CYC) && ((f % LL) < H_ACT);
  endfunction

  function automatic int pidx(input int f);
    return (f / LL) * H_ACT + (f % LL);
  endfunction

  function automatic logic [PW-1:0] exp_pix(input int f);
    logic [7:0] h, v;
    h = 8'(f % LL);
    v = 8'(f / LL);
    if (PAT) return {h, v, h ^ v};
    else     return mem_word(AW'(pidx(f)));
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [AW-1:0] apipe [4];
    logic [AW-1:0] a_seen;

    always_ff @(posedge clk) begin
      apipe[0] <= addr_w[g];
      for (int i = 1; i < 4; i++) apipe[i] <= apipe[i-1];
    end

    assign a_seen     = (L == 1) ? addr_w[g] : apipe[(L >= 2) ? (L - 2) : 0];
    assign rdata_w[g] = mem_word(a_seen);

    vid_frame_source #(
      .IW0(IW0), .IW1(IW1), .AW(AW), .H_ACT(H_ACT), .V_ACT(V_ACT),
      .H_BLANK(H_BLANK), .V_BLANK(V_BLANK), .RD_LAT(L)
    ) u_dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .start      (start),
      .cont       (cont),
      .busy       (busy_w[g]),
      .frame_done (fd_w[g]),
      .rd_en      (rde_w[g]),
      .rd_addr    (addr_w[g]),
      .rd_data    (rdata_w[g]),
      .hvalid     (hv_w[g]),
      .vvalid     (vv_w[g]),
      .dx_out     (dx_w[g]),
      .dy_out     (dy_w[g]),
      .grad_out   (gr_w[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s.g%0d.busy", tag, g), 32'(busy_w[g]), 32'd0);
      check($sformatf("%s.g%0d.frame_done", tag, g), 32'(fd_w[g]), 32'd0);
      check($sformatf("%s.g%0d.rd_en", tag, g), 32'(rde_w[g]), 32'd0);
      check($sformatf("%s.g%0d.rd_addr", tag, g), 32'(addr_w[g]), 32'd0);
      check($sformatf("%s.g%0d.hvalid", tag, g), 32'(hv_w[g]), 32'd0);
      check($sformatf("%s.g%0d.vvalid", tag, g), 32'(vv_w[g]), 32'd0);
      check($sformatf("%s.g%0d.pix", tag, g), 32'({dx_w[g], dy_w[g], gr_w[g]}), 32'd0);
    end
  endtask

  task automatic run_table(input string tag);
    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      start = vecs[r].start;
      @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
        check($sformatf("%s.r%0d.g%0d.busy", tag, r, g), 32'(busy_w[g]), 32'(vecs[r].busy));
        check($sformatf("%s.r%0d.g%0d.frame_done", tag, r, g), 32'(fd_w[g]), 32'(vecs[r].fd));
        check($sformatf("%s.r%0d.g%0d.rd_en", tag, r, g), 32'(rde_w[g]), 32'(vecs[r].rde));
        if (vecs[r].chk_addr)
          check($sformatf("%s.r%0d.g%0d.rd_addr", tag, r, g), 32'(addr_w[g]), 32'(vecs[r].addr));
        check($sformatf("%s.r%0d.g%0d.hvalid", tag, r, g), 32'(hv_w[g]), 32'(vecs[r].hv[g]));
        check($sformatf("%s.r%0d.g%0d.vvalid", tag, r, g), 32'(vv_w[g]), 32'(vecs[r].vv[g]));
        check($sformatf("%s.r%0d.g%0d.pix", tag, r, g), 32'({dx_w[g], dy_w[g], gr_w[g]}),
              32'(vecs[r].pix[g]));
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int fdc;
    int npix;
    int fd_times [$];
    logic vv_hist [101];
    logic busy_hist [101];
    int runs [$];
    int zr;
    bit seen_one;

    // Row t is sampled just after the t-th edge following the start edge; row 10 is a stray start.
    for (int t = 0; t < NV; t++) begin
      vecs[t].start    = (t == 0) || (t == 10);
      vecs[t].busy     = (t >= 1) && (t <= FRAME);
      vecs[t].fd       = (t == FRAME);
      vecs[t].rde      = !PAT && act_f(t - 1);
      vecs[t].chk_addr = vecs[t].rde || (t == 0) || (t > FRAME) || PAT;
      vecs[t].addr     = vecs[t].rde ? AW'(pidx(t - 1)) : {AW{1'b0}};
      for (int g = 0; g < NI; g++) begin
        int f;
        f = t - 1 - lat_of(g);
        vecs[t].hv[g]  = act_f(f);
        vecs[t].vv[g]  = (f >= 0) && (f < ACT_CYC);
        vecs[t].pix[g] = act_f(f) ? exp_pix(f) : {PW{1'b0}};
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(posedge clk);

    run_table("single");
    repeat (3) @(posedge clk);

    // Reset arrives while pixel 5 (line 1, h 1) is on the RD_LAT=2 outputs.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst.hvalid", 32'(hv_w[0]), 32'd1);
    check("pre_rst.pix", 32'({dx_w[0], dy_w[0], gr_w[0]}), 32'(exp_pix(7)));
    #2;
    rst_b = 1'b0;
    #1;
    check_idle("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    fdc = 0;
    for (int t = 0; t < 30; t++) begin
      @(posedge clk);
      #1;
      if (fd_w[0] || fd_w[1] || fd_w[2]) fdc++;
    end
    check("post_rst.frame_done_count", 32'(fdc), 32'd0);
    check("post_rst.busy", 32'(busy_w[0]), 32'd0);

    run_table("after_rst");
    repeat (3) @(posedge clk);

    // Continuous mode: cont dropped during frame 3 so the run ends after three frames.
    cont = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    npix = 0;
    for (int t = 1; t <= 100; t++) begin
      @(posedge clk);
      #1;
      vv_hist[t]   = vv_w[0];
      busy_hist[t] = busy_w[0];
      if (fd_w[0]) fd_times.push_back(t);
      if (hv_w[0]) npix++;
      if ((t == 1) || (t == FRAME + 1) || (t == 2 * FRAME + 1)) begin
        check($sformatf("cont.t%0d.rd_en", t), 32'(rde_w[0]), 32'(!PAT));
        check($sformatf("cont.t%0d.rd_addr", t), 32'(addr_w[0]), 32'd0);
      end
      if (t == 60) cont = 1'b0;
    end
    check("cont.frame_done_count", 32'(fd_times.size()), 32'd3);
    for (int i = 0; i < fd_times.size(); i++)
      check($sformatf("cont.frame_done_time%0d", i), 32'(fd_times[i]), 32'((i + 1) * FRAME));
    check("cont.pixel_count", 32'(npix), 32'(3 * H_ACT * V_ACT));
    check("cont.busy_last", 32'(busy_hist[3 * FRAME]), 32'd1);
    check("cont.busy_after", 32'(busy_hist[3 * FRAME + 1]), 32'd0);

    seen_one = 1'b0;
    zr = 0;
    for (int t = 1; t <= 100; t++) begin
      if (vv_hist[t]) begin
        if (seen_one && (zr > 0)) runs.push_back(zr);
        seen_one = 1'b1;
        zr = 0;
      end else begin
        zr++;
      end
    end
    check("cont.vblank_gap_count", 32'(runs.size()), 32'd2);
    for (int i = 0; i < runs.size(); i++)
      check($sformatf("cont.vblank_gap%0d", i), 32'(runs[i]), 32'(V_BLANK * LL));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
